// File: rtl/systolic_sequencer.sv
// Sequencer for an N x N output-stationary systolic array: latches A/B, skews them onto the array edges.
// Optional macro SYSTOLIC_SEQ_ABORT_EN adds i_abort to cancel a running job.
module systolic_sequencer #(
  parameter int N = 4
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_start,
  output logic             o_ready,
  input  logic [N*N*8-1:0] i_matA,
  input  logic [N*N*8-1:0] i_matB,
  output logic [N*8-1:0]   o_a,
  output logic [N*8-1:0]   o_b,
  output logic             o_doProcess,
  output logic             o_valid,
`ifdef SYSTOLIC_SEQ_ABORT_EN
  input  logic             i_abort,
`endif
  input  logic             i_ack
);

  localparam int CNT_W = $clog2(3*N-2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(3*N-3);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [N*N*8-1:0]   mat_a, mat_b;
  logic               load;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state <= IDLE;
      cnt   <= '0;
      mat_a <= '0;
      mat_b <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        mat_a <= i_matA;
        mat_b <= i_matB;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          load      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = FEED;
        end
      end
      FEED: begin
        if (cnt == LAST) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        if (i_ack) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
`ifdef SYSTOLIC_SEQ_ABORT_EN
    if (i_abort && (state != IDLE)) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
`endif
  end

  // Element (i,k) of A enters row i, and (k,j) of B enters column j, on the cycle where i+k (k+j) equals cnt.
  always_comb begin
    o_a         = '0;
    o_b         = '0;
    o_ready     = (state == IDLE);
    o_doProcess = (state != IDLE);
    o_valid     = (state == DONE);
    if (state == FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(cnt) == i + k) begin
            o_a[i*8 +: 8] = mat_a[(i*N+k)*8 +: 8];
            o_b[i*8 +: 8] = mat_b[(k*N+i)*8 +: 8];
          end
        end
      end
    end
  end

endmodule
